// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: producer/consumer side of the RAM-backed FIFO controller.
//
// Signals:
//   push, push_data      producer write request and data
//   push_ready           push accepted this cycle when push & push_ready
//   pop                  consumer read request
//   pop_ready            pop accepted this cycle when pop & pop_ready
//   pop_data, pop_valid  registered read data and its one-cycle valid pulse
//   empty, full, afull   occupancy flags
//   count                occupancy, 0..2**ADDR_W
//   busy                 RAM clear sequence in progress
//
// Modports: master = producer/consumer side, slave = FIFO controller.

interface ram_fifo_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              empty;
    logic              full;
    logic              afull;
    logic [ADDR_W:0]   count;
    logic              busy;

    modport master (
        output push, push_data, pop,
        input  push_ready, pop_ready, pop_data, pop_valid,
        input  empty, full, afull, count, busy
    );

    modport slave (
        input  push, push_data, pop,
        output push_ready, pop_ready, pop_data, pop_valid,
        output empty, full, afull, count, busy
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-port FIFO controller driving a 2**ADDR_W x DATA_W RAM with a
// combinational read port. At most one RAM access (push write or pop read) per cycle;
// contention between push and pop is resolved by a toggling priority bit.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   fifo       ram_fifo_ctrl_if.slave: push/pop handshakes, pop data, status flags
//   m_cen      RAM chip enable
//   m_wen      RAM write enable (1 = write, 0 = read)
//   m_addr     RAM address
//   m_din      RAM write data
//   m_dout     RAM read data (combinational from m_addr)
//
// Optional feature macro RAM_CLEAR_EN: when defined, reset enters an init state that
// writes zero to every RAM address (busy=1, both readies 0), then switches to run.
// When undefined, the controller is in run state straight out of reset and busy is 0.

module ram_fifo_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned AFULL_LVL = 28
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_fifo_ctrl_if.slave    fifo,
    output logic              m_cen,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              prio_q, prio_d;     // 0: pop wins contention, 1: push wins
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
`ifdef RAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

    logic run;
    logic is_empty, is_full;
    logic push_req_ok, pop_req_ok;
    logic push_ready, pop_ready;
    logic push_acc, pop_acc;

    // Handshake and arbitration
    always_comb begin
        run         = (state_q == StRun);
        is_empty    = (count_q == '0);
        is_full     = (count_q == DepthCnt);
        push_req_ok = fifo.push & ~is_full;
        pop_req_ok  = fifo.pop & ~is_empty;
        pop_ready   = run & ~is_empty & (~push_req_ok | ~prio_q);
        push_ready  = run & ~is_full & (~pop_req_ok | prio_q);
        push_acc    = fifo.push & push_ready;
        pop_acc     = fifo.pop & pop_ready;
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        prio_d      = prio_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = pop_acc;
`ifdef RAM_CLEAR_EN
        clr_addr_d  = clr_addr_q;
        if (state_q == StInit) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == '1) begin
                state_d = StRun;
            end
        end
`endif
        // Priority only flips when both sides actually contended
        if (run && push_req_ok && pop_req_ok) begin
            prio_d = ~prio_q;
        end
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + (ADDR_W + 1)'(1);
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            count_d    = count_q - (ADDR_W + 1)'(1);
            pop_data_d = m_dout;
        end
    end

    // RAM drive; push and pop acceptance are mutually exclusive and both 0 during init
    always_comb begin
        m_cen  = 1'b0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_din  = '0;
`ifdef RAM_CLEAR_EN
        if (state_q == StInit) begin
            m_cen  = 1'b1;
            m_wen  = 1'b1;
            m_addr = clr_addr_q;
        end
`endif
        if (push_acc) begin
            m_cen  = 1'b1;
            m_wen  = 1'b1;
            m_addr = wr_ptr_q;
            m_din  = fifo.push_data;
        end
        if (pop_acc) begin
            m_cen  = 1'b1;
            m_wen  = 1'b0;
            m_addr = rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
`ifdef RAM_CLEAR_EN
            state_q    <= StInit;
            clr_addr_q <= '0;
`else
            state_q    <= StRun;
`endif
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            prio_q      <= 1'b0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
`ifdef RAM_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            prio_q      <= prio_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    always_comb begin
        fifo.push_ready = push_ready;
        fifo.pop_ready  = pop_ready;
        fifo.pop_data   = pop_data_q;
        fifo.pop_valid  = pop_valid_q;
        fifo.empty      = is_empty;
        fifo.full       = is_full;
        fifo.afull      = (32'(count_q) >= AFULL_LVL);
        fifo.count      = count_q;
`ifdef RAM_CLEAR_EN
        fifo.busy       = (state_q == StInit);
`else
        fifo.busy       = 1'b0;
`endif
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Single-port FIFO controller placed directly upstream of the 32x32 `ram` block.
- Converts push/pop handshakes from the producer/consumer into `ram` cen/wen/addr/din cycles.
- Registers `ram` dout as pop data.
- Maintains read/write pointers, occupancy, full/empty and almost-full. At most one RAM access per cycle.

Parameters:
- DATA_W, 32, data width; matches `ram` din/dout.
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W = 32.
- AFULL_LVL, 28, count at or above which afull asserts.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- push  input  1  producer write request.
- push_data  input  DATA_W  write data.
- push_ready  output  1  push accepted this cycle when push & push_ready.
- pop  input  1  consumer read request.
- pop_ready  output  1  pop accepted this cycle when pop & pop_ready.
- pop_data  output  DATA_W  read data, registered.
- pop_valid  output  1  pop_data valid; 1-cycle pulse.
- empty  output  1  count == 0.
- full  output  1  count == 32.
- afull  output  1  count >= AFULL_LVL.
- count  output  ADDR_W+1  occupancy, 0..32.
- busy  output  1  init sequence in progress.
- m_cen  output  1  to `ram` cen.
- m_wen  output  1  to `ram` wen; 1 = write, 0 = read.
- m_addr  output  ADDR_W  to `ram` addr.
- m_din  output  DATA_W  to `ram` din.
- m_dout  input  DATA_W  from `ram` dout.

Behaviour:
- RAM contract:
  - Write at posedge when cen=1 and wen=1.
  - Read is combinational: dout = mem[addr] while cen=1 and wen=0.
- Reset (reset_n=0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, prio=0 (pop-first), pop_data=0, pop_valid=0.
  - FSM goes to INIT when RAM_CLEAR_EN is defined, else RUN.
  - Reset mid-operation discards all contents and any in-flight pop.
- FSM states: INIT, RUN.
  - INIT → RUN after clr_addr wraps 31→0.
  - RUN is held until reset.
- Ready signals (combinational, RUN only; both 0 in INIT):
  - pop_ready = !empty & (!push_req_ok | prio==0).
  - push_ready = !full & (!pop_req_ok | prio==1).
  - pop_req_ok = pop & !empty; push_req_ok = push & !full.
- Arbitration:
  - When pop_req_ok and push_req_ok are both true, prio selects the winner and then toggles.
  - A lone request does not toggle prio.
- RAM drive (combinational from the accepted op):
  - Push: m_cen=1, m_wen=1, m_addr=wr_ptr, m_din=push_data.
  - Pop: m_cen=1, m_wen=0, m_addr=rd_ptr.
  - Idle: m_cen=0, m_wen=0, m_addr=0, m_din=0.
- Accepted push: wr_ptr <= wr_ptr+1 (mod 32, natural wrap); count+1.
- Accepted pop:
  - pop_data <= m_dout; pop_valid <= 1 next cycle.
  - rd_ptr <= rd_ptr+1 (mod 32); count-1.
  - Latency: pop_data is valid 1 cycle after acceptance.
  - pop_data holds its value when no pop is accepted; pop_valid <= 0.
- Simultaneous events:
  - Push and pop are never both accepted in the same cycle, so count never moves by ±2.
  - Push when full → ignored.
  - Pop when empty → ignored; no RAM cycle is issued.
- Boundaries:
  - Pointers wrap 31→0.
  - full and empty are derived from count, never from pointer equality.

Optional Feature:
- Macro RAM_CLEAR_EN.
- Defined:
  - After reset the FSM enters INIT and writes 0 to addresses 0..31, one per cycle (m_cen=1, m_wen=1, m_addr=clr_addr, m_din=0).
  - busy=1 and push_ready=pop_ready=0 for 32 cycles, then RUN.
- Undefined:
  - No INIT state; busy is tied to 0.
  - RUN is active on the first cycle after reset release.

Test Plan:
- Reset then push 1,2,3,4 on consecutive cycles → m_wen=1, m_addr 0..3; count=4; empty=0.
- Pop ×4 → pop_valid pulses one cycle after each accept with pop_data 1,2,3,4; count=0; empty=1.
- Push 32 words A0..BF (hex low byte) → full=1; afull=1 from count 28; extra push gives push_ready=0 and count stays 32. Then pop 32 words → data in order; wr_ptr/rd_ptr wrap to 0.
- Preload 2 words, then hold push and pop together for 4 cycles → grants alternate pop,push,pop,push; count returns to 2; data order preserved.
- Pop on empty → pop_ready=0, m_cen=0, pop_valid stays 0. Assert reset_n=0 with count=5 → next cycle count=0, empty=1, pop_valid=0.
- With RAM_CLEAR_EN → busy=1 for exactly 32 cycles after reset with m_addr 0..31 and m_din=0; push is refused during INIT and accepted on cycle 33.
